// File: rtl/skid_buffer_flush_async_rstn.sv
// skid_buffer_flush_async_rstn
//
// Two-entry valid/ready pipeline stage with a synchronous flush. It decouples
// a producer from a consumer at full throughput. s_ready comes straight from
// a register, so there is no combinational path from m_ready to s_ready.
//
// State table:
//   state | meaning
//   EMPTY | main and skid both invalid (occupancy 0)
//   BUSY  | main valid, skid invalid   (occupancy 1)
//   FULL  | main and skid both valid   (occupancy 2)
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   flush      synchronous kill of all buffered entries, active-high
//   s_valid    upstream payload valid
//   s_ready    stage can accept (registered)
//   s_data     upstream payload, WIDTH bits
//   m_valid    downstream payload valid (masked during flush)
//   m_ready    downstream accepts
//   m_data     downstream payload (reads zero during flush)
//   occupancy  number of valid entries, 0..2 (registered)

module skid_buffer_flush_async_rstn #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_valid, skid_valid;
  logic             in_xfer, out_xfer;
  logic             load_main_in, load_main_skid, load_skid_in;

  // The state encoding equals the entry count, so the valid bits and the
  // occupancy are decoded directly from the state register.
  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);
  assign occupancy  = state;

  assign s_ready = !skid_valid;
  assign m_valid = main_valid & !flush;
  assign m_data  = flush ? '0 : main_data;

  // m_valid already carries the flush mask, so no out-transfer can occur in
  // a flush cycle.
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      // Any in-transfer this cycle is consumed and dropped.
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_next   = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_next   = FULL;
            load_skid_in = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next     = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Data registers load only on demand; invalid entries keep stale contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= s_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_data <= s_data;
      end
    end
  end

endmodule
